// File: rtl/wb_pkg.sv
// Shared write-back types and sizes for the register-file write-back arbiter.
package wb_pkg;

  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_STARVE_MAX = 3;

  // One queued write-back: destination register and its data.
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO that holds mul/div results while the ALU owns the write port.
module wb_skid_fifo
  import wb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam logic [1:0] CNT_FULL = 2'(WB_FIFO_DEPTH);

  wb_entry_t  mem_q [WB_FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_push_s;
  logic       do_pop_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == 2'd0);
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and 1-bit wrap-around pointers; reset drops any queued entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results take priority, mul/div results
// queue in a 2-entry FIFO, and a starvation counter forces a one-cycle ALU stall.
// Optional macro WB_ARBITER_FWD_EN adds operand forwarding compare outputs.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              alu_stall,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              err_alu_ovr
`ifdef WB_ARBITER_FWD_EN
  ,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data
`endif
);

  localparam logic [1:0] STARVE_MAX = 2'(WB_STARVE_MAX);

  logic              wr_en_q,     wr_en_d;
  logic [REG_W-1:0]  wr_rd_q,     wr_rd_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic              alu_stall_q, alu_stall_d;
  logic              err_q,       err_d;
  logic [1:0]        starve_q,    starve_d;

  logic      alu_win_s;
  logic      pop_s;
  logic      push_s;
  logic      fifo_full_s;
  logic      fifo_empty_s;
  wb_entry_t fifo_head_s;
  wb_entry_t push_entry_s;

  // Acceptance depends only on occupancy, never on a same-cycle pop.
  assign md_ready     = rst_n & ~fifo_full_s;
  assign alu_win_s    = alu_valid & (alu_rd != 5'd0);
  assign pop_s        = ~alu_win_s & ~fifo_empty_s;
  assign push_s       = md_valid & md_ready & (md_rd != 5'd0);
  assign push_entry_s = '{rd: md_rd, data: md_data};

  wb_skid_fifo u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (fifo_head_s)
  );

  // Winner selection, starvation tracking and sticky overrun flag.
  always_comb begin
    wr_en_d   = alu_win_s | pop_s;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (alu_win_s) begin
      wr_rd_d   = alu_rd;
      wr_data_d = alu_data;
    end else if (pop_s) begin
      wr_rd_d   = fifo_head_s.rd;
      wr_data_d = fifo_head_s.data;
    end else begin
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
    end

    starve_d = starve_q;
    if (alu_stall_q || fifo_empty_s || pop_s) begin
      starve_d = 2'd0;
    end else if (alu_win_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 2'd1;
    end else begin
      starve_d = starve_q;
    end

    alu_stall_d = (starve_d == STARVE_MAX);
    err_d       = err_q | (alu_valid & alu_stall_q);
  end

  // All arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_rd_q     <= 5'd0;
      wr_data_q   <= 32'd0;
      alu_stall_q <= 1'b0;
      err_q       <= 1'b0;
      starve_q    <= 2'd0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_rd_q     <= wr_rd_d;
      wr_data_q   <= wr_data_d;
      alu_stall_q <= alu_stall_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_rd       = wr_rd_q;
  assign wr_data     = wr_data_q;
  assign alu_stall   = alu_stall_q;
  assign err_alu_ovr = err_q;

`ifdef WB_ARBITER_FWD_EN
  assign fwd_a_hit  = wr_en_q & (wr_rd_q == rs);
  assign fwd_b_hit  = wr_en_q & (wr_rd_q == rt);
  assign fwd_a_data = wr_data_q;
  assign fwd_b_data = wr_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus multi-cycle sequences.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        alu_stall;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        err_alu_ovr;
`ifdef WB_ARBITER_FWD_EN
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_a_data;
  logic [31:0] fwd_b_data;
`endif

  int tests;
  int fails;

  wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .alu_stall   (alu_stall),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data),
    .err_alu_ovr (err_alu_ovr)
`ifdef WB_ARBITER_FWD_EN
    ,
    .rs          (rs),
    .rt          (rt),
    .fwd_a_hit   (fwd_a_hit),
    .fwd_b_hit   (fwd_b_hit),
    .fwd_a_data  (fwd_a_data),
    .fwd_b_data  (fwd_b_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdd;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdd);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    md_valid  = mv;
    md_rd     = mrd;
    md_data   = mdd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   {31'd0, wr_en},       32'd0);
    chk({tag, "_wr_rd"},   {27'd0, wr_rd},       32'd0);
    chk({tag, "_wr_data"}, wr_data,              32'd0);
    chk({tag, "_stall"},   {31'd0, alu_stall},   32'd0);
    chk({tag, "_err"},     {31'd0, err_alu_ovr}, 32'd0);
    chk({tag, "_md_rdy"},  {31'd0, md_ready},    32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    md_valid = 1'b0;  md_rd = 5'd0;  md_data = 32'd0;
`ifdef WB_ARBITER_FWD_EN
    rs = 5'd0; rt = 5'd0;
`endif

    //            av    ard    ad             mv    mrd    mdd           wen   rd     data          rdy   stall
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd3,  32'h33,       1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd4,  32'h44,       1'b1, 5'd3,  32'h33,       1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 5'd4,  32'h44,       1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b0, 5'd4,  32'h44,       1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd6,  32'h66,       1'b1, 5'd1,  32'h11,       1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd7,  32'h77,       1'b1, 5'd2,  32'h22,       1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd8,  32'h88,       1'b1, 5'd9,  32'h99,       1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd10, 32'hAA,       1'b0, 5'd0,  32'd0,        1'b1, 5'd10, 32'hAA,       1'b0, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 5'd6,  32'h66,       1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 5'd7,  32'h77,       1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  32'h5678,     1'b0, 5'd7,  32'h77,       1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b0, 5'd7,  32'h77,       1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("post_rst_md_rdy", {31'd0, md_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].mdd);
      chk($sformatf("v%0d_wr_en", i),   {31'd0, wr_en},     {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d_wr_rd", i),   {27'd0, wr_rd},     {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_wr_data", i), wr_data,            vecs[i].e_data);
      chk($sformatf("v%0d_md_rdy", i),  {31'd0, md_ready},  {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_stall", i),   {31'd0, alu_stall}, {31'd0, vecs[i].e_stall});
    end

    // Starvation with one queued entry: three starved ALU cycles, then a stall
    step(1'b1, 5'd1, 32'h101, 1'b1, 5'd12, 32'hC0C0);
    chk("sA0_wr_rd", {27'd0, wr_rd}, 32'd1);
    step(1'b1, 5'd2, 32'h102, 1'b0, 5'd0, 32'd0);
    chk("sA1_stall", {31'd0, alu_stall}, 32'd0);
    step(1'b1, 5'd3, 32'h103, 1'b0, 5'd0, 32'd0);
    chk("sA2_stall", {31'd0, alu_stall}, 32'd0);
    step(1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'd0);
    chk("sA3_stall", {31'd0, alu_stall}, 32'd1);
    chk("sA3_wr_rd", {27'd0, wr_rd}, 32'd4);
    idle();
    chk("sA4_wr_en",   {31'd0, wr_en},       32'd1);
    chk("sA4_wr_rd",   {27'd0, wr_rd},       32'd12);
    chk("sA4_wr_data", wr_data,              32'hC0C0);
    chk("sA4_stall",   {31'd0, alu_stall},   32'd0);
    chk("sA4_err",     {31'd0, err_alu_ovr}, 32'd0);

    // Illegal ALU traffic during the stall cycle
    step(1'b1, 5'd1, 32'h201, 1'b1, 5'd13, 32'hD0D0);
    step(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd3, 32'h203, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd4, 32'h204, 1'b0, 5'd0, 32'd0);
    chk("sB3_stall", {31'd0, alu_stall}, 32'd1);
    step(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'd0);
    chk("sB4_wr_en",   {31'd0, wr_en},       32'd1);
    chk("sB4_wr_rd",   {27'd0, wr_rd},       32'd20);
    chk("sB4_wr_data", wr_data,              32'h2020);
    chk("sB4_err",     {31'd0, err_alu_ovr}, 32'd1);
    chk("sB4_stall",   {31'd0, alu_stall},   32'd0);
    idle();
    chk("sB5_wr_rd",   {27'd0, wr_rd},       32'd13);
    chk("sB5_wr_data", wr_data,              32'hD0D0);
    chk("sB5_err",     {31'd0, err_alu_ovr}, 32'd1);
    idle();
    chk("sB6_wr_en",   {31'd0, wr_en},       32'd0);
    chk("sB6_err",     {31'd0, err_alu_ovr}, 32'd1);

    // Reset with two entries queued: nothing queued before reset is written after
    step(1'b1, 5'd1, 32'h301, 1'b1, 5'd14, 32'hE0E0);
    step(1'b1, 5'd2, 32'h302, 1'b1, 5'd15, 32'hF0F0);
    chk("sC1_md_rdy", {31'd0, md_ready}, 32'd0);
    alu_valid = 1'b0;
    md_valid  = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("sC_post%0d_wr_en", i), {31'd0, wr_en}, 32'd0);
    end

    // Acceptance on the first edge after reset release
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h1616);
    chk("sD0_wr_en", {31'd0, wr_en}, 32'd0);
    idle();
    chk("sD1_wr_en",   {31'd0, wr_en}, 32'd1);
    chk("sD1_wr_rd",   {27'd0, wr_rd}, 32'd16);
    chk("sD1_wr_data", wr_data,        32'h1616);

`ifdef WB_ARBITER_FWD_EN
    step(1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0);
    rs = 5'd7;
    rt = 5'd8;
    #1;
    chk("fwd_a_hit",  {31'd0, fwd_a_hit}, 32'd1);
    chk("fwd_b_hit",  {31'd0, fwd_b_hit}, 32'd0);
    chk("fwd_a_data", fwd_a_data,         32'h7777);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
